kamacore_stage_writeback: RTL and testbench

Consumer (WB) end of the MEM/WB stage interface. Registers the MEM/WB bundle, waits for the data-memory read response on loads, and aligns and sign/zero-extends load data. Drives the single register-file write port and a retired-instruction counter. It is the last pipeline stage; its stall output back-pressures MEM and earlier stages.

---
 rtl/kamacore_pkg.sv | 19 +
 rtl/kamacore_load_align.sv | 42 ++++
 rtl/kamacore_stage_writeback.sv | 131 +++++++++++++
 tb/tb_kamacore_stage_writeback.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// Shared widths, load funct3 encodings and the writeback FSM state type
// for the kamacore writeback stage.
package kamacore_pkg;

  localparam int cpu_width      = 31;
  localparam int reg_addr_width = 4;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } wb_state_t;

endpackage

// File: rtl/kamacore_load_align.sv
// Combinational load aligner: picks the byte/halfword lane from a
// word-aligned read and sign- or zero-extends it according to funct3.
module kamacore_load_align
  import kamacore_pkg::*;
#(
  parameter int W = cpu_width + 1
) (
  input  logic [W-1:0] word_i,
  input  logic [1:0]   addr_i,
  input  logic [2:0]   funct3_i,
  output logic [W-1:0] data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = word_i[7:0];
    case (addr_i)
      2'd0: byteLane = word_i[7:0];
      2'd1: byteLane = word_i[15:8];
      2'd2: byteLane = word_i[23:16];
      2'd3: byteLane = word_i[31:24];
      default: byteLane = word_i[7:0];
    endcase
    // Halfword loads ignore addr bit 0; misalignment is the producer's problem.
    halfLane = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      LOAD_LB:  data_o = {{(W-8){byteLane[7]}}, byteLane};
      LOAD_LH:  data_o = {{(W-16){halfLane[15]}}, halfLane};
      LOAD_LBU: data_o = {{(W-8){1'b0}}, byteLane};
      LOAD_LHU: data_o = {{(W-16){1'b0}}, halfLane};
      LOAD_LW:  data_o = word_i;
      default:  data_o = word_i;
    endcase
  end

endmodule

// File: rtl/kamacore_stage_writeback.sv
// Writeback stage: registers the MEM/WB bundle, waits for load data,
// drives the register-file write port and counts retired instructions.
module kamacore_stage_writeback
  import kamacore_pkg::*;
#(
  parameter int CPU_WIDTH      = cpu_width,
  parameter int REG_ADDR_WIDTH = reg_addr_width
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    hold_i,
  input  logic                    in_valid_i,
  input  logic [REG_ADDR_WIDTH:0] in_destination_register_i,
  input  logic [CPU_WIDTH:0]      in_data_memory_result_i,
  input  logic                    in_control_memory_read_i,
  input  logic                    in_control_write_register_i,
  input  logic [2:0]              in_load_funct3_i,
  input  logic                    mem_resp_valid_i,
  input  logic [CPU_WIDTH:0]      mem_resp_data_i,
  output logic                    wb_stall_o,
  output logic                    rf_write_enable_o,
  output logic [REG_ADDR_WIDTH:0] rf_write_address_o,
  output logic [CPU_WIDTH:0]      rf_write_data_o,
  output logic                    retire_pulse_o,
  output logic [63:0]             retired_count_o,
  output logic                    spurious_resp_o
);

  logic                    valid_q;
  logic [REG_ADDR_WIDTH:0] rd_q;
  logic [CPU_WIDTH:0]      result_q;
  logic                    is_load_q;
  logic                    writes_rd_q;
  logic [2:0]              funct3_q;
  logic                    done_q;
  logic                    discard_q;
  logic                    spurious_q;
  logic [63:0]             count_q;
  wb_state_t               state_q, state_d;

  logic               respLive;
  logic               loadPending;
  logic               retire;
  logic [CPU_WIDTH:0] loadData;

  // A response owed to a flushed load must never be mistaken for ours.
  assign respLive    = mem_resp_valid_i && !discard_q;
  assign loadPending = valid_q && is_load_q && !done_q;
  assign retire      = valid_q && !done_q && (!is_load_q || respLive);

  assign wb_stall_o         = loadPending && !respLive;
  assign retire_pulse_o     = retire;
  assign rf_write_enable_o  = retire && writes_rd_q && (rd_q != '0);
  assign rf_write_address_o = rd_q;
  assign rf_write_data_o    = is_load_q ? loadData : result_q;
  assign retired_count_o    = count_q;
  assign spurious_resp_o    = spurious_q;

  kamacore_load_align #(
    .W(CPU_WIDTH + 1)
  ) u_align (
    .word_i  (mem_resp_data_i),
    .addr_i  (result_q[1:0]),
    .funct3_i(funct3_q),
    .data_o  (loadData)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!hold_i) begin
      if (clear_i) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:     if (loadPending && !respLive) state_d = WAIT_MEM;
          WAIT_MEM: if (respLive || !loadPending) state_d = IDLE;
          default:  state_d = IDLE;
        endcase
      end
    end
  end

  // done_q remembers a retirement that happened under hold so it is not repeated.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q     <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      is_load_q   <= 1'b0;
      writes_rd_q <= 1'b0;
      funct3_q    <= '0;
      done_q      <= 1'b0;
    end else if (hold_i) begin
      if (retire) done_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (!wb_stall_o) begin
      valid_q     <= in_valid_i;
      rd_q        <= in_destination_register_i;
      result_q    <= in_data_memory_result_i;
      is_load_q   <= in_control_memory_read_i;
      writes_rd_q <= in_control_write_register_i;
      funct3_q    <= in_load_funct3_i;
      done_q      <= 1'b0;
    end
  end

  // Memory responses and retirements are tracked even under hold so none is lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= '0;
      discard_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (retire) count_q <= count_q + 64'd1;
      if (mem_resp_valid_i) begin
        if (discard_q)         discard_q  <= 1'b0;
        else if (!loadPending) spurious_q <= 1'b1;
      end
      if (!hold_i && clear_i && state_q == WAIT_MEM && loadPending && !respLive)
        discard_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kamacore_stage_writeback.sv
// Directed scoreboard bench for kamacore_stage_writeback: stimulus pushes
// expected writes, a negedge monitor pops them on every retirement.
module tb_kamacore_stage_writeback;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        hold;
  logic        inValid;
  logic [4:0]  inRd;
  logic [31:0] inResult;
  logic        inMemRead;
  logic        inWriteReg;
  logic [2:0]  inFunct3;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        wbStall;
  logic        rfWriteEnable;
  logic [4:0]  rfWriteAddress;
  logic [31:0] rfWriteData;
  logic        retirePulse;
  logic [63:0] retiredCount;
  logic        spuriousResp;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } expWb_t;

  expWb_t expQ[$];
  int checks   = 0;
  int failures = 0;

  kamacore_stage_writeback dut (
    .clk_i                      (clk),
    .reset_i                    (reset),
    .clear_i                    (clear),
    .hold_i                     (hold),
    .in_valid_i                 (inValid),
    .in_destination_register_i  (inRd),
    .in_data_memory_result_i    (inResult),
    .in_control_memory_read_i   (inMemRead),
    .in_control_write_register_i(inWriteReg),
    .in_load_funct3_i           (inFunct3),
    .mem_resp_valid_i           (memRespValid),
    .mem_resp_data_i            (memRespData),
    .wb_stall_o                 (wbStall),
    .rf_write_enable_o          (rfWriteEnable),
    .rf_write_address_o         (rfWriteAddress),
    .rf_write_data_o            (rfWriteData),
    .retire_pulse_o             (retirePulse),
    .retired_count_o            (retiredCount),
    .spurious_resp_o            (spuriousResp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] res,
                               input logic ld, input logic wr, input logic [2:0] f3);
    inValid    = v;
    inRd       = rd;
    inResult   = res;
    inMemRead  = ld;
    inWriteReg = wr;
    inFunct3   = f3;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic pushExp(input logic we, input logic [4:0] addr, input logic [31:0] data);
    expWb_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    expWb_t e;
    if (!reset && retirePulse) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_retire actual=1 expected=0 rd=%0d", rfWriteAddress);
      end else begin
        e = expQ.pop_front();
        checkOutput("rf_we", {63'd0, rfWriteEnable}, {63'd0, e.we});
        if (e.we) begin
          checkOutput("rf_addr", {59'd0, rfWriteAddress}, {59'd0, e.addr});
          checkOutput("rf_data", {32'd0, rfWriteData}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    int stallCycles;
    int weCount;
    reset = 1'b1;
    clear = 1'b0;
    hold  = 1'b0;
    memRespValid = 1'b0;
    memRespData  = 32'd0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", {63'd0, wbStall}, 64'd0);
    checkOutput("reset_we", {63'd0, rfWriteEnable}, 64'd0);
    checkOutput("reset_retire", {63'd0, retirePulse}, 64'd0);
    checkOutput("reset_count", retiredCount, 64'd0);
    checkOutput("reset_spurious", {63'd0, spuriousResp}, 64'd0);
    step();
    reset = 1'b0;

    // Plain ALU op: written the cycle after capture.
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 1'b1, 3'd0);
    pushExp(1'b1, 5'd5, 32'h1234);
    step();
    bubble();
    step();
    @(negedge clk);
    checkOutput("count_after_alu", retiredCount, 64'd1);

    // LB lane 3 then LHU upper half, both with same-cycle responses.
    step();
    applyStimulus(1'b1, 5'd11, 32'h1003, 1'b1, 1'b1, 3'b000);
    pushExp(1'b1, 5'd11, 32'hFFFF_FF80);
    step();
    applyStimulus(1'b1, 5'd12, 32'h1002, 1'b1, 1'b1, 3'b101);
    pushExp(1'b1, 5'd12, 32'h0000_80FF);
    memRespValid = 1'b1;
    memRespData  = 32'h80FF_FF00;
    step();
    bubble();
    step();
    memRespValid = 1'b0;

    // LW whose response arrives three cycles late, next bundle waiting.
    applyStimulus(1'b1, 5'd7, 32'h2000, 1'b1, 1'b1, 3'b010);
    pushExp(1'b1, 5'd7, 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b1, 5'd8, 32'hAA, 1'b0, 1'b1, 3'd0);
    pushExp(1'b1, 5'd8, 32'hAA);
    stallCycles = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wbStall) stallCycles++;
      step();
    end
    checkOutput("late_load_stall_cycles", 64'(stallCycles), 64'd3);
    memRespValid = 1'b1;
    memRespData  = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("stall_released_by_resp", {63'd0, wbStall}, 64'd0);
    step();
    bubble();
    memRespValid = 1'b0;
    step();
    @(negedge clk);
    checkOutput("count_after_loads", retiredCount, 64'd5);

    // x0 write and a non-writing op both retire without a write.
    step();
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 1'b1, 3'd0);
    pushExp(1'b0, 5'd0, 32'h55);
    step();
    applyStimulus(1'b1, 5'd3, 32'h66, 1'b0, 1'b0, 3'd0);
    pushExp(1'b0, 5'd3, 32'h66);
    step();
    // Back-to-back ALU ops, one write per cycle.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b1, 3'd0);
      pushExp(1'b1, 5'(i), 32'h100 + 32'(i));
      step();
    end
    bubble();
    step();
    @(negedge clk);
    checkOutput("count_after_b2b", retiredCount, 64'd10);

    // Hold for four cycles over a retiring ALU op.
    step();
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 3'd0);
    pushExp(1'b1, 5'd9, 32'h99);
    step();
    hold = 1'b1;
    bubble();
    weCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rfWriteEnable) weCount++;
      step();
    end
    hold = 1'b0;
    checkOutput("hold_single_write", 64'(weCount), 64'd1);
    step();
    @(negedge clk);
    checkOutput("count_after_hold", retiredCount, 64'd11);

    // Flush a load stuck in WAIT_MEM; its late response must be swallowed.
    step();
    applyStimulus(1'b1, 5'd10, 32'h3000, 1'b1, 1'b1, 3'b010);
    step();
    bubble();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    memRespValid = 1'b1;
    memRespData  = 32'h1111_1111;
    step();
    memRespValid = 1'b0;
    @(negedge clk);
    checkOutput("discarded_resp_not_spurious", {63'd0, spuriousResp}, 64'd0);
    step();
    memRespValid = 1'b1;
    step();
    memRespValid = 1'b0;
    @(negedge clk);
    checkOutput("unsolicited_resp_spurious", {63'd0, spuriousResp}, 64'd1);
    step();
    step();
    @(negedge clk);
    checkOutput("spurious_sticky", {63'd0, spuriousResp}, 64'd1);
    checkOutput("count_final", retiredCount, 64'd11);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
